pueo_beam_thresh_n: RTL and testbench
=====================================

Name: pueo_beam_thresh_n

Overview:
N-beam boxcar threshold trigger for the PUEO beamformer.
- Each clock, every beam delivers two power samples. They are summed into T, and T is boxcar-summed over NTAPS valid clocks.
- The boxcar sum is compared against a per-beam, double-buffered threshold, with a programmable per-beam retrigger holdoff.
- Sits between the beam power-sum stage and the trigger aggregator. Generalises the fixed 2-beam, 2-tap threshold block to N beams, a parametrised window, a valid qualifier and holdoff.

Parameters:
NBEAMS, 8, number of beams (1..64)
INW, 17, unsigned width of each input sample
THW, 18, unsigned threshold width
NTAPS, 2, boxcar length in valid clocks (1..4)
HOLDW, 4, holdoff counter width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous active-low
beam_i  in  NBEAMS*2*INW  beam b: sample0 at [(2b)*INW +: INW], sample1 at [(2b+1)*INW +: INW]
beam_valid_i  in  1  qualifies beam_i this clock
thresh_i  in  THW  threshold write data
thresh_addr_i  in  clog2(NBEAMS) (min 1)  beam index for write
thresh_wr_i  in  1  write thresh_i to shadow[thresh_addr_i]
update_i  in  1  copy all shadows to active thresholds
holdoff_i  in  HOLDW  holdoff length in valid samples, common to all beams
trigger_o  in/out: out  NBEAMS  per-beam trigger
trigger_valid_o  out  1  qualifies trigger_o

Behaviour:
- Reset, asynchronous, any time including mid-stream:
  - trigger_o=0, trigger_valid_o=0.
  - History registers=0, holdoff counters=0.
  - Shadow and active thresholds = all ones (2^THW-1), so no trigger is possible until programmed.
- Arithmetic, all unsigned, no overflow possible:
  - T = s0 + s1, width INW+1.
  - S = sum of the current T and the previous NTAPS-1 valid Ts. Width SW = INW+1+clog2(NTAPS).
  - Compare is done in max(SW,THW) bits with zero-extension.
  - Strict compare: hit = S > active_thresh.
- Pipeline, fixed latency 2:
  - Stage 1 registers T and shifts the history only when beam_valid_i=1.
  - Stage 2 registers trigger_o.
  - Valid presented in cycle k produces trigger_valid_o=1 in cycle k+2.
  - Invalid cycles never advance the history, the holdoff or the outputs. trigger_valid_o=0 and trigger_o=0 on those output cycles.
- History fill after reset: the history is zeros, so the first NTAPS-1 sums are partial. This is intended and must not be masked.
- Thresholds:
  - thresh_wr_i writes the shadow only.
  - update_i copies every shadow to active in one clock.
  - wr and update in the same cycle: active receives the pre-write shadow; the new value needs a later update.
  - thresh_addr_i >= NBEAMS: write ignored.
  - Samples presented in cycle k use the active value loaded at or before the edge closing cycle k-1. Equivalently, update in cycle u affects samples presented in cycles >= u+1.
- Holdoff, per beam, evaluated at stage 2 on valid samples only:
  - trigger_o[b] = hit & (hold[b]==0).
  - If the trigger fires, hold[b] <= holdoff_i.
  - Else if hold[b] != 0, hold[b] decrements.
  - Result: holdoff_i=H suppresses the next H valid samples. H=0 means no suppression; a sustained hit then triggers every valid sample.
  - holdoff_i is sampled at the firing edge only; changes do not affect running counts.
- Simultaneous events: a hit during holdoff is dropped, not queued, and does not reload the counter.

Decomposition:
- Package pueo_beam_thresh_pkg:
  - Function for sum width SW.
  - Threshold reset constant (all ones).
  - Localparam for address width with minimum 1.
- Sub-module pueo_beam_thresh_chan, one per beam via generate:
  - Contains the T adder, NTAPS history, boxcar sum, compare and holdoff counter.
  - Takes valid, active threshold and holdoff as inputs.
- Top level owns the shadow/active threshold banks, the address decode and the valid pipeline.

Test Plan:
- Basic threshold: defaults; write thresh 80000 to beam 0, update. Feed beam 0 with 20000/20000 for two valid clocks, then 20001/20000. Required: trigger_o[0]=0 for the sum 80000; trigger_o[0]=1 two clocks after the third sample (S=80001). All other beams stay 0.
- Staged update: shadow[3]=100 with no update -> no trigger on S=1000. Assert wr(3,500) and update together -> still 100 active, so the sample after triggers. A second update loads 500 -> S=400 gives no trigger.
- Holdoff: beam 2 thresh 0 with constant hit and holdoff_i=3. Required: trigger pattern 1,0,0,0,1,0,0,0 over valid samples. With holdoff_i=0 the pattern is every sample =1.
- Valid gaps: interleave beam_valid_i=0 cycles. Required: history and holdoff frozen; trigger_valid_o tracks valid delayed by 2; results identical to the gap-free stream.
- NTAPS=1 and NTAPS=4 builds: S equals T and the 4-sample sum respectively. Check the max input (all ones) sums without overflow against thresh 2^THW-1.
- Reset mid-stream with holdoff running: rst_n_i low for 1 cycle asynchronously. Required: outputs 0 immediately; thresholds revert to all ones, so no triggers until reprogrammed and updated.

Source files
------------

// File: rtl/pueo_beam_thresh_pkg.sv
// Shared widths and constants for the PUEO N-beam boxcar threshold trigger.
// Sizing helpers are functions because the widths depend on module parameters.
package pueo_beam_thresh_pkg;

  localparam int ADDR_W_MIN = 1;
  localparam int MAX_THW    = 64;

  // Power-on threshold: all ones, sliced down to THW by the user.
  localparam logic [MAX_THW-1:0] THRESH_ALL_ONES = '1;

  // Boxcar sum width: pair sum (INW+1) grown by log2 of the window length.
  function automatic int sumWidth(input int inw, input int ntaps);
    return inw + 1 + $clog2(ntaps);
  endfunction

  function automatic int addrWidth(input int nbeams);
    return (nbeams > 1) ? $clog2(nbeams) : ADDR_W_MIN;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pueo_beam_thresh_chan.sv
// One beam: pair adder, NTAPS boxcar over valid clocks, strict compare and
// retrigger holdoff. Stage 1 captures the hit, stage 2 applies the holdoff.
module pueo_beam_thresh_chan
  import pueo_beam_thresh_pkg::*;
#(
  parameter int INW   = 17,
  parameter int THW   = 18,
  parameter int NTAPS = 2,
  parameter int HOLDW = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [INW-1:0]   s0_i,
  input  logic [INW-1:0]   s1_i,
  input  logic             valid_i,
  input  logic             validS1_i,
  input  logic [THW-1:0]   thresh_i,
  input  logic [HOLDW-1:0] holdoff_i,
  output logic             trigger_o
);

  localparam int TW = INW + 1;
  localparam int SW = sumWidth(INW, NTAPS);
  localparam int CW = maxInt(SW, THW);
  localparam int HN = (NTAPS > 1) ? NTAPS - 1 : 1;

  logic [TW-1:0]    pairSum;
  logic [SW-1:0]    boxSum;
  logic             hit;
  logic [TW-1:0]    hist_q [HN];
  logic             hit_q;
  logic [HOLDW-1:0] hold_q;
  logic [HOLDW-1:0] hold_d;
  logic             trig_q;
  logic             trig_d;

  // hist_q holds the previous NTAPS-1 valid pair sums; zeros after reset give partial sums.
  always_comb begin
    pairSum = TW'(s0_i) + TW'(s1_i);
    boxSum  = SW'(pairSum);
    for (int i = 0; i < NTAPS - 1; i++) begin
      boxSum = boxSum + SW'(hist_q[i]);
    end
    hit = CW'(boxSum) > CW'(thresh_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < HN; i++) begin
        hist_q[i] <= '0;
      end
      hit_q <= 1'b0;
    end else if (valid_i) begin
      hist_q[0] <= pairSum;
      for (int i = 1; i < HN; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
      hit_q <= hit;
    end
  end

  // A hit during holdoff is dropped and does not reload the counter.
  always_comb begin
    trig_d = 1'b0;
    hold_d = hold_q;
    if (validS1_i) begin
      trig_d = hit_q && (hold_q == '0);
      if (trig_d) begin
        hold_d = holdoff_i;
      end else if (hold_q != '0) begin
        hold_d = hold_q - HOLDW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q <= '0;
      trig_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      trig_q <= trig_d;
    end
  end

  assign trigger_o = trig_q;

endmodule

// File: rtl/pueo_beam_thresh_n.sv
// N-beam boxcar threshold trigger: double-buffered per-beam thresholds,
// per-beam channels and the two-stage valid pipeline.
module pueo_beam_thresh_n
  import pueo_beam_thresh_pkg::*;
#(
  parameter int NBEAMS = 8,
  parameter int INW    = 17,
  parameter int THW    = 18,
  parameter int NTAPS  = 2,
  parameter int HOLDW  = 4,
  localparam int AW    = addrWidth(NBEAMS)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NBEAMS*2*INW-1:0] beam_i,
  input  logic                    beam_valid_i,
  input  logic [THW-1:0]          thresh_i,
  input  logic [AW-1:0]           thresh_addr_i,
  input  logic                    thresh_wr_i,
  input  logic                    update_i,
  input  logic [HOLDW-1:0]        holdoff_i,
  output logic [NBEAMS-1:0]       trigger_o,
  output logic                    trigger_valid_o
);

  logic [THW-1:0] shadow_q [NBEAMS];
  logic [THW-1:0] active_q [NBEAMS];
  logic           validS1_q;
  logic           validS2_q;
  logic           addrOk;

  assign addrOk = ({{(32-AW){1'b0}}, thresh_addr_i} < 32'(NBEAMS));

  // Nonblocking copy means a same-cycle write lands in shadow only; active gets the old shadow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        shadow_q[b] <= THRESH_ALL_ONES[THW-1:0];
        active_q[b] <= THRESH_ALL_ONES[THW-1:0];
      end
    end else begin
      if (thresh_wr_i && addrOk) begin
        shadow_q[thresh_addr_i] <= thresh_i;
      end
      if (update_i) begin
        for (int b = 0; b < NBEAMS; b++) begin
          active_q[b] <= shadow_q[b];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      validS1_q <= 1'b0;
      validS2_q <= 1'b0;
    end else begin
      validS1_q <= beam_valid_i;
      validS2_q <= validS1_q;
    end
  end

  assign trigger_valid_o = validS2_q;

  for (genvar b = 0; b < NBEAMS; b++) begin : gBeam
    pueo_beam_thresh_chan #(
      .INW  (INW),
      .THW  (THW),
      .NTAPS(NTAPS),
      .HOLDW(HOLDW)
    ) uChan (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .s0_i     (beam_i[(2*b)*INW +: INW]),
      .s1_i     (beam_i[(2*b+1)*INW +: INW]),
      .valid_i  (beam_valid_i),
      .validS1_i(validS1_q),
      .thresh_i (active_q[b]),
      .holdoff_i(holdoff_i),
      .trigger_o(trigger_o[b])
    );
  end

endmodule

// File: tb/tb_pueo_beam_thresh_n.sv
// Directed self-checking bench for pueo_beam_thresh_n: a default 8-beam build
// plus single-beam NTAPS=1 and NTAPS=4 builds sharing one stimulus port.
module tb_pueo_beam_thresh_n;

  localparam int NB    = 8;
  localparam int INW   = 17;
  localparam int THW   = 18;
  localparam int HOLDW = 4;
  localparam int XTHW  = 20;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i;
  logic [NB*2*INW-1:0]  beam_i;
  logic                 beam_valid_i;
  logic [THW-1:0]       thresh_i;
  logic [2:0]           thresh_addr_i;
  logic                 thresh_wr_i;
  logic                 update_i;
  logic [HOLDW-1:0]     holdoff_i;
  logic [NB-1:0]        trigger_o;
  logic                 trigger_valid_o;

  logic [2*INW-1:0]     xBeam;
  logic                 xValid;
  logic [XTHW-1:0]      xThresh;
  logic [0:0]           xAddr;
  logic                 xWr;
  logic                 xUpd;
  logic [HOLDW-1:0]     xHold;
  logic [0:0]           trigA;
  logic                 trigValidA;
  logic [0:0]           trigB;
  logic                 trigValidB;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [NB-1:0] expTrigPrev;
  logic          expValPrev;
  string         tagPrev;

  int gapV [10] = '{1, 0, 1, 0, 0, 1, 1, 0, 1, 1};
  int gapE [10] = '{4, 0, 0, 0, 0, 0, 0, 0, 4, 0};

  always #5 clk_i = ~clk_i;

  pueo_beam_thresh_n #(
    .NBEAMS(NB), .INW(INW), .THW(THW), .NTAPS(2), .HOLDW(HOLDW)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .beam_i         (beam_i),
    .beam_valid_i   (beam_valid_i),
    .thresh_i       (thresh_i),
    .thresh_addr_i  (thresh_addr_i),
    .thresh_wr_i    (thresh_wr_i),
    .update_i       (update_i),
    .holdoff_i      (holdoff_i),
    .trigger_o      (trigger_o),
    .trigger_valid_o(trigger_valid_o)
  );

  pueo_beam_thresh_n #(
    .NBEAMS(1), .INW(INW), .THW(XTHW), .NTAPS(1), .HOLDW(HOLDW)
  ) dutA (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .beam_i         (xBeam),
    .beam_valid_i   (xValid),
    .thresh_i       (xThresh),
    .thresh_addr_i  (xAddr),
    .thresh_wr_i    (xWr),
    .update_i       (xUpd),
    .holdoff_i      (xHold),
    .trigger_o      (trigA),
    .trigger_valid_o(trigValidA)
  );

  pueo_beam_thresh_n #(
    .NBEAMS(1), .INW(INW), .THW(XTHW), .NTAPS(4), .HOLDW(HOLDW)
  ) dutB (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .beam_i         (xBeam),
    .beam_valid_i   (xValid),
    .thresh_i       (xThresh),
    .thresh_addr_i  (xAddr),
    .thresh_wr_i    (xWr),
    .update_i       (xUpd),
    .holdoff_i      (xHold),
    .trigger_o      (trigB),
    .trigger_valid_o(trigValidB)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setBeam(input int b, input int s0, input int s1);
    beam_i[(2*b)*INW +: INW]   = INW'(s0);
    beam_i[(2*b+1)*INW +: INW] = INW'(s1);
  endtask

  task automatic writeThresh(input int addr, input int value);
    thresh_addr_i = 3'(addr);
    thresh_i      = THW'(value);
    thresh_wr_i   = 1'b1;
  endtask

  // One cycle of stimulus; the output now visible belongs to the previous call's sample.
  task automatic applyStimulus(input logic v, input logic [NB-1:0] eTrig, input string tag);
    beam_valid_i = v;
    tick();
    thresh_wr_i = 1'b0;
    update_i    = 1'b0;
    checkOutput({tagPrev, ".trig"},  32'(trigger_o),       32'(expTrigPrev));
    checkOutput({tagPrev, ".valid"}, 32'(trigger_valid_o), 32'(expValPrev));
    expTrigPrev = v ? eTrig : '0;
    expValPrev  = v;
    tagPrev     = tag;
  endtask

  task automatic xSample(input logic expA, input logic expB, input string tag);
    xValid = 1'b1;
    tick();
    xValid = 1'b0;
    tick();
    checkOutput({tag, ".A"},      32'(trigA),      32'(expA));
    checkOutput({tag, ".Avalid"}, 32'(trigValidA), 32'd1);
    checkOutput({tag, ".B"},      32'(trigB),      32'(expB));
    checkOutput({tag, ".Bvalid"}, 32'(trigValidB), 32'd1);
  endtask

  task automatic xProgram(input int value);
    xAddr   = 1'b0;
    xThresh = XTHW'(value);
    xWr     = 1'b1;
    tick();
    xWr  = 1'b0;
    xUpd = 1'b1;
    tick();
    xUpd = 1'b0;
  endtask

  initial begin
    rst_n_i       = 1'b0;
    beam_i        = '0;
    beam_valid_i  = 1'b0;
    thresh_i      = '0;
    thresh_addr_i = '0;
    thresh_wr_i   = 1'b0;
    update_i      = 1'b0;
    holdoff_i     = '0;
    xBeam         = '0;
    xValid        = 1'b0;
    xThresh       = '0;
    xAddr         = '0;
    xWr           = 1'b0;
    xUpd          = 1'b0;
    xHold         = '0;
    expTrigPrev   = '0;
    expValPrev    = 1'b0;
    tagPrev       = "reset";

    repeat (3) tick();
    checkOutput("reset.trig",   32'(trigger_o),       32'd0);
    checkOutput("reset.valid",  32'(trigger_valid_o), 32'd0);
    checkOutput("reset.trigA",  32'(trigA),           32'd0);
    checkOutput("reset.trigB",  32'(trigB),           32'd0);
    #2 rst_n_i = 1'b1;
    tick();

    // Reset thresholds are all ones: S equal to 2^18-1 is not a hit, one more is.
    setBeam(1, 65536, 65535);
    applyStimulus(1'b1, 8'h00, "A.partial");
    setBeam(1, 65536, 65536);
    applyStimulus(1'b1, 8'h00, "A.eqOnes");
    applyStimulus(1'b1, 8'h02, "A.gtOnes");
    beam_i = '0;
    applyStimulus(1'b0, 8'h00, "A.f1");
    applyStimulus(1'b0, 8'h00, "A.f2");

    // Basic threshold on beam 0.
    writeThresh(0, 80000);
    applyStimulus(1'b0, 8'h00, "B.wr");
    update_i = 1'b1;
    applyStimulus(1'b0, 8'h00, "B.upd");
    setBeam(0, 20000, 20000);
    applyStimulus(1'b1, 8'h00, "B.s1");
    applyStimulus(1'b1, 8'h00, "B.eq80000");
    setBeam(0, 20001, 20000);
    applyStimulus(1'b1, 8'h01, "B.gt80001");
    beam_i = '0;
    applyStimulus(1'b0, 8'h00, "B.f1");
    applyStimulus(1'b0, 8'h00, "B.f2");

    // Staged update on beam 3.
    writeThresh(3, 100);
    applyStimulus(1'b0, 8'h00, "C.wr100");
    setBeam(3, 500, 500);
    applyStimulus(1'b1, 8'h00, "C.noUpd");
    writeThresh(3, 500);
    update_i = 1'b1;
    setBeam(3, 0, 0);
    applyStimulus(1'b1, 8'h00, "C.wrUpdSame");
    setBeam(3, 100, 100);
    applyStimulus(1'b1, 8'h08, "C.old100");
    update_i = 1'b1;
    applyStimulus(1'b0, 8'h00, "C.upd500");
    applyStimulus(1'b1, 8'h00, "C.new500");
    beam_i = '0;
    applyStimulus(1'b0, 8'h00, "C.f1");
    applyStimulus(1'b0, 8'h00, "C.f2");

    // Holdoff on beam 2 with a threshold of zero and a constant hit.
    writeThresh(2, 0);
    applyStimulus(1'b0, 8'h00, "D.wr0");
    update_i = 1'b1;
    applyStimulus(1'b0, 8'h00, "D.upd");
    holdoff_i = 4'd3;
    setBeam(2, 1, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, (i == 0 || i == 4) ? 8'h04 : 8'h00, $sformatf("D.h3.%0d", i));
    end
    holdoff_i = 4'd0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h04, $sformatf("D.h0.%0d", i));
    end
    applyStimulus(1'b0, 8'h00, "D.f1");
    holdoff_i = 4'd3;

    // Same holdoff stream with invalid gaps interleaved.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(gapV[i] != 0, NB'(gapE[i]), $sformatf("E.gap.%0d", i));
    end

    // Holdoff still counting down; reset hits while trigger_o[2] is high.
    applyStimulus(1'b1, 8'h00, "F.s7");
    applyStimulus(1'b1, 8'h00, "F.s8");
    applyStimulus(1'b1, 8'h04, "F.s9");
    applyStimulus(1'b0, 8'h00, "F.gap");
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("F.rst.trig",  32'(trigger_o),       32'd0);
    checkOutput("F.rst.valid", 32'(trigger_valid_o), 32'd0);
    @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    tick();
    expTrigPrev = '0;
    expValPrev  = 1'b0;
    tagPrev     = "F.rst";
    applyStimulus(1'b1, 8'h00, "F.post1");
    applyStimulus(1'b1, 8'h00, "F.post2");
    writeThresh(2, 0);
    applyStimulus(1'b1, 8'h00, "F.wrOnly");
    applyStimulus(1'b1, 8'h00, "F.noUpd");
    update_i = 1'b1;
    applyStimulus(1'b1, 8'h00, "F.updCycle");
    applyStimulus(1'b1, 8'h04, "F.afterUpd");
    applyStimulus(1'b0, 8'h00, "F.f1");
    applyStimulus(1'b0, 8'h00, "F.f2");

    // NTAPS=1 and NTAPS=4 builds with full-scale inputs; addr 1 is out of range.
    xAddr   = 1'b1;
    xThresh = '0;
    xWr     = 1'b1;
    tick();
    xWr  = 1'b0;
    xUpd = 1'b1;
    tick();
    xUpd  = 1'b0;
    xBeam = '1;
    xSample(1'b0, 1'b0, "X.badAddr");
    xProgram(1048567);
    xSample(1'b0, 1'b0, "X.fill2");
    xSample(1'b0, 1'b0, "X.fill3");
    xSample(1'b0, 1'b1, "X.full4");
    xProgram(262142);
    xSample(1'b0, 1'b1, "X.eqT");
    xProgram(262141);
    xSample(1'b1, 1'b1, "X.gtT");
    tick();
    checkOutput("X.idle.Avalid", 32'(trigValidA), 32'd0);
    checkOutput("X.idle.B",      32'(trigB),      32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
